if_fetch_unit: RTL and testbench

- Instruction fetch stage for the 5-stage MIPS pipeline; generates PC sequence, issues instruction-memory reads, buffers returned words, presents them to decode (whose opcode field feeds the control unit).
- Closes the loop on the control unit's Jump/Branch/BEQFlag outputs: applies jump redirects from ID and branch redirects from EX, flushing wrong-path words.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS front end: opcodes seen by the control unit,
// fetch FSM states and the prefetch buffer entry layout.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch buffer; flush empties it in one cycle
// and takes priority over push and pop.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic do_push, do_pop;

  assign do_push = push & ~flush & (count_reg != FULL);
  assign do_pop  = pop & ~flush & (count_reg != '0);

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, FWFT
// buffering to decode, jump/branch redirects. FETCH_PERF_EN adds perf counters.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  input  logic        id_jump,
  input  logic [25:0] id_jump_index,
  input  logic        ex_branch,
  input  logic        ex_beq_flag,
  input  logic        ex_zero,
  input  logic [31:0] ex_branch_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  fetch_state_e     state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_reg, drop_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             fifo_empty, push, pop, accept, resp_ok, discard;
  logic             branch_taken, jump_taken, redirect;
  logic [31:0]      redirect_target, resp_pc;
  fetch_entry_t     head, push_entry;

  always_comb begin
    branch_taken    = ex_branch & (ex_beq_flag ? ex_zero : ~ex_zero);
    jump_taken      = id_jump & id_valid;
    redirect        = (state_reg != BOOT) & (branch_taken | jump_taken);
    // The branch sits in EX and is older than the jump in ID, so it wins.
    redirect_target = branch_taken ? ex_branch_target
                                   : {id_pc_plus4[31:28], id_jump_index, 2'b00};

    credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_reg};
    imem_req_valid = (state_reg == RUN) & ~redirect & (credit_used < DEPTH_C);
    accept         = imem_req_valid & imem_req_ready;

    // Responses with nothing outstanding belong to pre-reset requests.
    resp_ok          = imem_resp_valid & (state_reg != BOOT) & (outstanding_reg != '0);
    discard          = resp_ok & (drop_reg != '0);
    outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(resp_ok);

    // With drop clear, outstanding requests are the words just below fetch_pc.
    resp_pc    = fetch_pc_reg - 32'({outstanding_reg, 2'b00});
    push_entry = '{instr: imem_resp_data, pc_plus4: resp_pc + 32'd4};
    push       = resp_ok & ~discard & (state_reg == RUN) & ~redirect;
    pop        = id_valid & id_ready & ~redirect;

    drop_next     = redirect ? outstanding_next
                             : (discard ? drop_reg - CNT_W'(1) : drop_reg);
    fetch_pc_next = redirect ? redirect_target
                             : (accept ? fetch_pc_reg + 32'd4 : fetch_pc_reg);

    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (redirect && outstanding_next != '0) state_next = DRAIN;
      DRAIN:   if (drop_next == '0) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign imem_addr   = fetch_pc_reg;
  assign id_valid    = ~fifo_empty;
  assign id_instr    = id_valid ? head.instr : '0;
  assign id_pc_plus4 = id_valid ? head.pc_plus4 : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg, perf_redirects_reg, perf_stall_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched_reg   <= '0;
      perf_redirects_reg <= '0;
      perf_stall_reg     <= '0;
    end else begin
      if (pop)                   perf_fetched_reg   <= perf_fetched_reg + 32'd1;
      if (redirect)              perf_redirects_reg <= perf_redirects_reg + 32'd1;
      if (id_ready && !id_valid) perf_stall_reg     <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetched   = perf_fetched_reg;
  assign perf_redirects = perf_redirects_reg;
  assign perf_stall     = perf_stall_reg;
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: bench-side memory model plus a queue of
// expected decode-side PCs, compared on every word popped into ID.
module tb_if_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc_plus4;
  logic        id_jump;
  logic [25:0] id_jump_index;
  logic        ex_branch, ex_beq_flag, ex_zero;
  logic [31:0] ex_branch_target;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_instr         (id_instr),
    .id_pc_plus4      (id_pc_plus4),
    .id_jump          (id_jump),
    .id_jump_index    (id_jump_index),
    .ex_branch        (ex_branch),
    .ex_beq_flag      (ex_beq_flag),
    .ex_zero          (ex_zero),
    .ex_branch_target (ex_branch_target)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  bit          mem_hold = 0;
  bit          tb_redirect = 0;
  bit          want_first = 0;
  bit          got_first = 0;
  logic [31:0] first_req;
  int          acc_cnt = 0;
  int          pop_cnt = 0;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a ^ 32'h5A3C_0001;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_exp(logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 48; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Drive this cycle's memory response, let logic settle, then observe.
  task automatic eval();
    logic [31:0] e;
    if (!mem_hold && mem_q.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_addr);
      req_log.push_back(imem_addr);
      acc_cnt++;
      $display("req addr=%h", imem_addr);
      if (want_first) begin
        first_req  = imem_addr;
        got_first  = 1'b1;
        want_first = 1'b0;
      end
    end
    if (id_valid && id_ready && !tb_redirect) begin
      pop_cnt++;
      $display("id pop pc_plus4=%h instr=%h", id_pc_plus4, id_instr);
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(id_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("id_instr", id_instr, instr_of(e));
        chk("id_pc_plus4", id_pc_plus4, e + 32'd4);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    eval();
    adv();
  endtask

  task automatic redirect_cycle(logic [31:0] tgt);
    tb_redirect = 1'b1;
    eval();
    chk("redirect_no_req", 32'(imem_req_valid), 32'd0);
    load_exp(tgt);
    got_first  = 1'b0;
    want_first = 1'b1;
    adv();
    tb_redirect = 1'b0;
    ex_branch   = 1'b0;
    ex_zero     = 1'b0;
    id_jump     = 1'b0;
  endtask

  task automatic branch(logic [31:0] tgt);
    ex_branch        = 1'b1;
    ex_beq_flag      = 1'b1;
    ex_zero          = 1'b1;
    ex_branch_target = tgt;
    redirect_cycle(tgt);
  endtask

  task automatic wait_first(string tag, logic [31:0] tgt);
    for (int i = 0; i < 30 && !got_first; i++) tick();
    chk({tag, "_req_seen"}, 32'(got_first), 32'd1);
    if (got_first) chk(tag, first_req, tgt);
  endtask

  task automatic wait_valid(string tag);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      eval();
      if (id_valid) found = 1'b1;
      adv();
      if (found) break;
    end
    chk({tag, "_valid_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_pop(string tag);
    int p0 = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == p0; i++) tick();
    chk({tag, "_pop_seen"}, 32'(pop_cnt > p0), 32'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
    id_jump = 1'b0; id_jump_index = '0;
    ex_branch = 1'b0; ex_beq_flag = 1'b0; ex_zero = 1'b0; ex_branch_target = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    load_exp(32'h0);

    // Reset state, then release with 1-cycle memory and decode always ready
    tick();
    repeat (2) begin eval(); chk_reset_outputs(); adv(); end
    reset = 1'b1;
    req_log.delete(); acc_cnt = 0; pop_cnt = 0;
    eval(); chk("boot_no_req", 32'(imem_req_valid), 32'd0); adv();
    eval(); chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_addr, 32'h0); adv();
    eval(); chk("no_id_yet", 32'(id_valid), 32'd0); adv();
    eval(); chk("id_valid_cycle3", 32'(id_valid), 32'd1);
    chk("id_first_pc_plus4", id_pc_plus4, 32'h4); adv();
    repeat (6) tick();
    chk("req_seq0", req_log[0], 32'h0);
    chk("req_seq1", req_log[1], 32'h4);
    chk("req_seq2", req_log[2], 32'h8);

    // Decode stall: buffered + outstanding stays within DEPTH
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      eval();
      chk("credit_bound", 32'(acc_cnt - pop_cnt <= DEPTH), 32'd1);
      adv();
    end
    eval();
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_id_valid", 32'(id_valid), 32'd1);
    chk("stall_buffered", 32'(acc_cnt - pop_cnt), 32'(DEPTH));
    adv();
    id_ready = 1'b1;
    repeat (8) tick();

    // Taken BEQ with two requests outstanding
    imem_req_ready = 1'b0;
    repeat (4) tick();
    mem_hold = 1'b1; imem_req_ready = 1'b1;
    repeat (2) tick();
    branch(32'h0000_0040);
    chk("beq_outstanding", 32'(mem_q.size()), 32'd2);
    mem_hold = 1'b0;
    eval();
    chk("drain_no_req", 32'(imem_req_valid), 32'd0);
    chk("drain_id_empty", 32'(id_valid), 32'd0);
    adv();
    wait_first("beq_target", 32'h0000_0040);
    wait_pop("beq");

    // BNE with zero set is not taken
    ex_branch = 1'b1; ex_beq_flag = 1'b0; ex_zero = 1'b1; ex_branch_target = 32'h0000_0300;
    tick();
    ex_branch = 1'b0; ex_zero = 1'b0;
    begin
      int p0 = pop_cnt;
      repeat (6) tick();
      chk("bne_stream_continues", 32'(pop_cnt - p0 >= 3), 32'd1);
    end

    // PC wrap from 0xFFFF_FFFC to 0
    branch(32'hFFFF_FFF8);
    wait_first("wrap_target", 32'hFFFF_FFF8);
    repeat (8) tick();

    // Jump from the instruction whose pc_plus4 is 0x1000_0010
    id_ready = 1'b0;
    branch(32'h1000_000C);
    wait_first("jump_src", 32'h1000_000C);
    wait_valid("jump_src");
    id_jump = 1'b1; id_jump_index = 26'h000_0100;
    chk("jump_head_pc_plus4", id_pc_plus4, 32'h1000_0010);
    redirect_cycle(32'h1000_0400);
    wait_first("jump_target", 32'h1000_0400);

    // Jump and taken branch together: branch wins
    wait_valid("both_src");
    chk("both_head_pc_plus4", id_pc_plus4, 32'h1000_0404);
    id_jump = 1'b1; id_jump_index = 26'h3FF_FFFF;
    ex_branch = 1'b1; ex_beq_flag = 1'b1; ex_zero = 1'b1; ex_branch_target = 32'h0000_0080;
    redirect_cycle(32'h0000_0080);
    wait_first("branch_wins", 32'h0000_0080);
    id_ready = 1'b1;
    wait_pop("branch_wins");
    repeat (6) tick();

    // Reset with three requests outstanding; late responses must be ignored
    imem_req_ready = 1'b0;
    repeat (4) tick();
    mem_hold = 1'b1; imem_req_ready = 1'b1;
    repeat (3) tick();
    imem_req_ready = 1'b0;
    reset = 1'b0;
    eval(); chk("rst_outstanding", 32'(mem_q.size()), 32'd3); adv();
    eval(); chk_reset_outputs(); adv();
    reset = 1'b1; mem_hold = 1'b0;
    load_exp(32'h0); req_log.delete(); acc_cnt = 0; pop_cnt = 0;
    got_first = 1'b0; want_first = 1'b1;
    repeat (3) begin eval(); chk("late_resp_no_id", 32'(id_valid), 32'd0); adv(); end
    imem_req_ready = 1'b1;
    wait_first("post_reset_req", 32'h0);
    wait_pop("post_reset");
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
